// File: rtl/swap_pkg.sv
// Shared types and dual-rail select encodings for the swap control source.
package swap_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    EMIT  = 3'd2,
    WAITA = 3'd3,
    WAITN = 3'd4
  } state_t;

  localparam logic [1:0] CTL_NULL = 2'b00;
  localparam logic [1:0] CTL_A    = 2'b01;
  localparam logic [1:0] CTL_B    = 2'b10;

  // Token counter width, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-stage synchronizer with synchronous clear.
module sync_ff #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] stg;

  always_ff @(posedge clk) begin
    if (clr) stg <= '0;
    else     stg <= {stg[SYNC-2:0], d};
  end

  assign q = stg[SYNC-1];

endmodule

// File: rtl/swap_ctl_src.sv
// Serialises a bundled-data command word into dual-rail select tokens
// for a swap, one token per four-phase handshake, LSB first.
module swap_ctl_src
  import swap_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_i,
  output logic         a_i,
  input  logic [N-1:0] d_i,
  output logic         ctl_a,
  output logic         ctl_b,
  input  logic         actl_i,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CW = cnt_w(N);

  logic          r_s;
  logic          ack_s;
  state_t        state, state_n;
  logic [N-1:0]  sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    ctl, ctl_n;
  logic          a_n;
  logic          busy_n;
  logic          err_n;

  sync_ff #(.SYNC(SYNC)) u_sync_r (
    .clk (clk),
    .clr (rst),
    .d   (r_i),
    .q   (r_s)
  );

  sync_ff #(.SYNC(SYNC)) u_sync_ack (
    .clk (clk),
    .clr (rst),
    .d   (actl_i),
    .q   (ack_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      ctl   <= CTL_NULL;
      a_i   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      ctl   <= ctl_n;
      a_i   <= a_n;
      busy  <= busy_n;
      err   <= err_n;
    end
  end

  assign ctl_a = ctl[0];
  assign ctl_b = ctl[1];

  // Next-state and next-output logic; every output above is a flop.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    ctl_n   = ctl;
    a_n     = a_i;
    // An acknowledge with no token outstanding is a protocol violation.
    err_n   = err | (ack_s && (state == IDLE || state == HOLD || state == EMIT));

    unique case (state)
      IDLE: begin
        a_n   = 1'b0;
        ctl_n = CTL_NULL;
        if (r_s) begin
          sr_n    = d_i;
          cnt_n   = '0;
          a_n     = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (!r_s) begin
          a_n     = 1'b0;
          state_n = EMIT;
        end
      end
      EMIT: begin
        ctl_n   = sr[0] ? CTL_B : CTL_A;
        state_n = WAITA;
      end
      WAITA: begin
        if (ack_s) begin
          ctl_n   = CTL_NULL;
          state_n = WAITN;
        end
      end
      WAITN: begin
        if (!ack_s) begin
          if (cnt == CW'(N - 1)) begin
            state_n = IDLE;
          end else begin
            sr_n    = sr >> 1;
            cnt_n   = cnt + CW'(1);
            state_n = EMIT;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_swap_ctl_src.sv
// Randomised and directed bench for swap_ctl_src against a token-queue model.
module tb_swap_ctl_src;

  localparam int unsigned N    = 4;
  localparam int unsigned SYNC = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         r_i = 1'b0;
  logic         a_i;
  logic [N-1:0] d_i = '0;
  logic         ctl_a;
  logic         ctl_b;
  logic         actl_i = 1'b0;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  swap_ctl_src #(.N(N), .SYNC(SYNC)) dut (
    .clk    (clk),
    .rst    (rst),
    .r_i    (r_i),
    .a_i    (a_i),
    .d_i    (d_i),
    .ctl_a  (ctl_a),
    .ctl_b  (ctl_b),
    .actl_i (actl_i),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Behavioural model: a word becomes a queue of pending tokens, issued
  // one per handshake with the swap, observed through SYNC-deep delays.
  typedef enum int {P_IDLE, P_ACCEPT, P_ISSUE, P_WAIT_ACK, P_WAIT_REL} phase_t;
  phase_t          ph     = P_IDLE;
  int              tokens[$];
  logic [SYNC-1:0] rq     = '0;
  logic [SYNC-1:0] aq     = '0;
  logic            m_a    = 1'b0;
  logic [1:0]      m_ctl  = 2'b00;
  logic            m_busy = 1'b0;
  logic            m_err  = 1'b0;

  always @(posedge clk) begin
    logic rs, as;
    if (rst) begin
      ph = P_IDLE; tokens.delete(); rq = '0; aq = '0;
      m_a = 1'b0; m_ctl = 2'b00; m_err = 1'b0;
    end else begin
      rs = rq[SYNC-1];
      as = aq[SYNC-1];
      if (as && (ph == P_IDLE || ph == P_ACCEPT || ph == P_ISSUE)) m_err = 1'b1;
      case (ph)
        P_IDLE: if (rs) begin
          tokens.delete();
          for (int i = 0; i < int'(N); i++) tokens.push_back(int'(d_i[i]));
          m_a = 1'b1;
          ph  = P_ACCEPT;
        end
        P_ACCEPT: if (!rs) begin
          m_a = 1'b0;
          ph  = P_ISSUE;
        end
        P_ISSUE: begin
          m_ctl = (tokens[0] != 0) ? 2'b10 : 2'b01;
          ph    = P_WAIT_ACK;
        end
        P_WAIT_ACK: if (as) begin
          m_ctl = 2'b00;
          void'(tokens.pop_front());
          ph = P_WAIT_REL;
        end
        P_WAIT_REL: if (!as) ph = (tokens.size() == 0) ? P_IDLE : P_ISSUE;
        default: ph = P_IDLE;
      endcase
      rq = {rq[SYNC-2:0], r_i};
      aq = {aq[SYNC-1-1:0], actl_i};
    end
    m_busy = (ph != P_IDLE);
  end

  // Per-cycle comparison and token log, sampled on the falling edge.
  bit         checking = 0;
  logic [1:0] prev_ctl = 2'b00;
  int         log_q[$];

  always @(negedge clk) begin
    logic [1:0] c;
    c = {ctl_b, ctl_a};
    if (checking) begin
      chk("a_i", a_i, m_a);
      chk("ctl", c, m_ctl);
      chk("busy", busy, m_busy);
      chk("err", err, m_err);
      checks++;
      assert (!(ctl_a && ctl_b) && ($countones(c ^ prev_ctl) <= 1)) else begin
        errors++;
        $display("FAIL ctl_rail: got %b after %b at %0t", c, prev_ctl, $time);
      end
      if (c != prev_ctl && c != 2'b00) log_q.push_back(int'(c));
    end
    prev_ctl = c;
  end

  // Swap-side responder: acknowledges a token after resp_delay cycles.
  bit resp_en    = 1;
  int resp_delay = 3;
  initial begin
    int rc = 0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        if (!actl_i) begin
          if ({ctl_b, ctl_a} != 2'b00) begin
            rc++;
            if (rc >= resp_delay) begin actl_i = 1'b1; rc = 0; end
          end else rc = 0;
        end else if ({ctl_b, ctl_a} == 2'b00) begin
          rc++;
          if (rc >= 2) begin actl_i = 1'b0; rc = 0; end
        end
      end
    end
  end

  int last_lat;

  task automatic handshake(input logic [N-1:0] d);
    int t = 0;
    d_i = d;
    r_i = 1'b1;
    while (a_i !== 1'b1 && t < 800) begin @(negedge clk); t++; end
    if (t >= 800) timeout("ack_rise");
    last_lat = t;
    r_i = 1'b0;
    t = 0;
    while (a_i !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) timeout("ack_fall");
    d_i = N'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) timeout("idle");
  endtask

  task automatic wait_tokens(input int n);
    int t = 0;
    while (log_q.size() < n && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) timeout("token");
  endtask

  task automatic chk_word(input string name, input int base, input int e0, input int e1,
                          input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) chk(name, (base + i < log_q.size()) ? log_q[base + i] : -1, e[i]);
  endtask

  initial begin
    int base;
    int held;
    int early;
    int t;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checking = 1;
    chk("reset_ctl", {ctl_b, ctl_a}, 2'b00);
    chk("reset_busy", busy, 1'b0);
    repeat (2) @(negedge clk);

    // Alternating word, plus input-handshake latency from an idle block.
    base = log_q.size();
    handshake(4'b1010);
    chk("ack_latency", last_lat, SYNC + 1);
    wait_idle();
    chk_word("word_1010", base, 1, 2, 1, 2);
    chk("idle_busy", busy, 1'b0);

    // Reset while the second token of a word is outstanding.
    base = log_q.size();
    handshake(4'b0001);
    wait_tokens(base + 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ctl", {ctl_b, ctl_a}, 2'b00);
    chk("rst_a", a_i, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tok0", log_q[base], 2);
    chk("rst_tok1", log_q[base + 1], 1);
    base = log_q.size();
    handshake(4'b0110);
    wait_idle();
    chk_word("word_0110", base, 1, 2, 2, 1);

    // New request raised during the first token is held off until idle.
    base = log_q.size();
    handshake(4'b1100);
    wait_tokens(base + 1);
    d_i = 4'b0011;
    r_i = 1'b1;
    early = 0;
    t = 0;
    while (a_i !== 1'b1 && t < 800) begin
      if (log_q.size() < base + 4) early += int'(a_i);
      @(negedge clk);
      t++;
    end
    if (t >= 800) timeout("late_ack");
    chk("early_ack", early, 0);
    chk("tokens_before_ack", log_q.size() - base, 4);
    r_i = 1'b0;
    wait_idle();
    chk_word("word_1100", base, 1, 1, 2, 2);
    chk_word("word_0011", base + 4, 2, 2, 1, 1);

    // Spurious acknowledge while idle sets a sticky error.
    resp_en = 0;
    actl_i = 1'b1;
    repeat (2) @(negedge clk);
    actl_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("err_set", err, 1'b1);
    chk("err_ctl", {ctl_b, ctl_a}, 2'b00);
    resp_en = 1;
    base = log_q.size();
    handshake(4'b0101);
    wait_idle();
    chk("err_sticky", err, 1'b1);
    chk_word("word_0101", base, 2, 1, 2, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_clear", err, 1'b0);

    // Slow responder: token must hold for the whole delay.
    resp_delay = 20;
    handshake(4'b0010);
    t = 0;
    while ({ctl_b, ctl_a} == 2'b00 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("slow_token");
    held = 0;
    while ({ctl_b, ctl_a} == 2'b01 && held < 200) begin @(negedge clk); held++; end
    chk("hold20", held >= 20, 1'b1);
    wait_idle();

    // Random words under random responder and host pacing.
    for (int k = 0; k < 30; k++) begin
      resp_delay = int'($urandom_range(1, 6));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      handshake(N'($urandom));
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
